// File: rtl/s4ga_pkg.sv
// Shared definitions for the s4ga configuration path.
// Holds the streamer state encoding and the functions that turn the fabric
// parameters (N, K, SI_W) into image geometry. The fabric model and the
// testbench use the same functions, so all three agree on the layout.
package s4ga_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FRST = 2'd2,
        RUN  = 2'd3
    } s4ga_state_e;

    // Width of a LUT index.
    function automatic int calc_n_w(input int n);
        return $clog2(n);
    endfunction

    // Segments needed for one index field.
    function automatic int calc_idx_segs(input int n, input int si_w);
        return (calc_n_w(n) + si_w - 1) / si_w;
    endfunction

    // Segments needed for one truth-table mask.
    function automatic int calc_mask_segs(input int k, input int si_w);
        return ((1 << k) + si_w - 1) / si_w;
    endfunction

    // Segments per LUT frame: K index fields followed by the mask.
    function automatic int calc_ll(input int n, input int k, input int si_w);
        return k * calc_idx_segs(n, si_w) + calc_mask_segs(k, si_w);
    endfunction

    // Segments in a full configuration image.
    function automatic int calc_total(input int n, input int k, input int si_w);
        return n * calc_ll(n, k, si_w);
    endfunction

endpackage

// File: rtl/s4ga_cfg_ram.sv
// Configuration image store: DEPTH x D_W, one write port, one synchronous
// read port. Contents are not reset.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   write port, written on the rising edge
//   rd_en/rd_addr    read request; data appears on rd_data the next cycle
//   rd_data          registered read data, zero in any cycle following
//                    a cycle without rd_en
module s4ga_cfg_ram #(
    parameter int DEPTH = 15,
    parameter int A_W   = 4,
    parameter int D_W   = 4
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [A_W-1:0] wr_addr,
    input  logic [D_W-1:0] wr_data,
    input  logic           rd_en,
    input  logic [A_W-1:0] rd_addr,
    output logic [D_W-1:0] rd_data
);

    logic [D_W-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port; an idle read cycle drives zero so the output doubles as the
    // fabric's quiet bus value.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// Configuration sequencer for the s4ga LUT fabric.
// Loads one configuration image through a valid/ready port, then streams it
// to the fabric one segment per clock, wrapping continuously, while owning
// the fabric reset so segment 0 lands in the first non-reset fabric cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_start          pulse, begin an image load (honoured in IDLE only)
//   ld_valid/ld_data    load segment stream, ld_ready accepts
//   run_en              level, request streaming
//   loaded              a complete image is held
//   fab_rst             fabric reset
//   si                  segment to fabric
//   lut_n               LUT whose frame is currently on si
//   sweep_done          high while si carries the last image segment
//   state_o             FSM state
module s4ga_cfg_streamer
    import s4ga_pkg::*;
#(
    parameter int N       = 79,
    parameter int K       = 5,
    parameter int SI_W    = 4,
    parameter int RST_CYC = N + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   ld_valid,
    input  logic [SI_W-1:0]        ld_data,
    output logic                   ld_ready,
    input  logic                   run_en,
    output logic                   loaded,
    output logic                   fab_rst,
    output logic [SI_W-1:0]        si,
    output logic [calc_n_w(N)-1:0] lut_n,
    output logic                   sweep_done,
    output logic [1:0]             state_o
);

    localparam int N_W   = calc_n_w(N);
    localparam int LL    = calc_ll(N, K, SI_W);
    localparam int TOTAL = calc_total(N, K, SI_W);
    localparam int A_W   = $clog2(TOTAL);
    localparam int LL_W  = $clog2(LL + 1);
    localparam int RC_W  = $clog2(RST_CYC + 1);

    localparam logic [A_W-1:0]  ADDR_LAST = A_W'(TOTAL - 1);
    localparam logic [LL_W-1:0] SEG_LAST  = LL_W'(LL - 1);
    localparam logic [N_W-1:0]  LUT_LAST  = N_W'(N - 1);
    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYC - 1);

    s4ga_state_e     state_r, state_nx;
    logic [A_W-1:0]  wr_addr_r;
    logic [A_W-1:0]  rd_addr_r;     // address of the segment now on si
    logic [LL_W-1:0] seg_cnt_r;     // segment position within the current frame
    logic [N_W-1:0]  lut_n_r;
    logic [RC_W-1:0] rst_cnt_r;
    logic            stop_req_r;    // run_en dropped mid-sweep
    logic            loaded_r;
    logic            fab_rst_r;
    logic            ld_ready_r;
    logic            sweep_done_r;

    logic            wr_en_s;
    logic            rd_en_s;
    logic [A_W-1:0]  rd_addr_s;
    logic [A_W-1:0]  rd_next_s;
    logic            at_end_s;
    logic            stop_s;
    logic            run_hold_s;
    logic [SI_W-1:0] rd_data_s;

    s4ga_cfg_ram #(
        .DEPTH (TOTAL),
        .A_W   (A_W),
        .D_W   (SI_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_r),
        .wr_data (ld_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state, RAM control and read-address prefetch.
    always_comb begin
        state_nx  = state_r;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        rd_addr_s = '0;
        at_end_s  = (rd_addr_r == ADDR_LAST);
        rd_next_s = at_end_s ? '0 : (rd_addr_r + A_W'(1));
        stop_s    = stop_req_r | ~run_en;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_nx = LOAD;
                end else if (run_en && loaded_r) begin
                    state_nx = FRST;
                end else begin
                    state_nx = IDLE;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    wr_en_s  = 1'b1;
                    state_nx = (wr_addr_r == ADDR_LAST) ? IDLE : LOAD;
                end else begin
                    state_nx = LOAD;
                end
            end
            FRST: begin
                // Final reset cycle prefetches segment 0 so it is on si the
                // moment fab_rst falls.
                if (rst_cnt_r == RC_LAST) begin
                    state_nx  = RUN;
                    rd_en_s   = 1'b1;
                    rd_addr_s = '0;
                end else begin
                    state_nx = FRST;
                end
            end
            RUN: begin
                // Stopping is only allowed once the last segment is on si.
                if (at_end_s && stop_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx  = RUN;
                    rd_en_s   = 1'b1;
                    rd_addr_s = rd_next_s;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (rst) begin
            state_nx = IDLE;
            wr_en_s  = 1'b0;
            rd_en_s  = 1'b0;
        end else begin
            state_nx = state_nx;
        end
    end

    assign run_hold_s = (state_r == RUN) && (state_nx == RUN);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            wr_addr_r    <= '0;
            rd_addr_r    <= '0;
            seg_cnt_r    <= '0;
            lut_n_r      <= '0;
            rst_cnt_r    <= '0;
            stop_req_r   <= 1'b0;
            loaded_r     <= 1'b0;
            fab_rst_r    <= 1'b1;
            ld_ready_r   <= 1'b0;
            sweep_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx;
            fab_rst_r    <= (state_nx != RUN);
            ld_ready_r   <= (state_nx == LOAD);
            rd_addr_r    <= rd_addr_s;
            sweep_done_r <= rd_en_s && (rd_addr_s == ADDR_LAST);

            if ((state_r == IDLE) && load_start) begin
                wr_addr_r <= '0;
                loaded_r  <= 1'b0;
            end else if (wr_en_s) begin
                wr_addr_r <= (wr_addr_r == ADDR_LAST) ? '0 : (wr_addr_r + A_W'(1));
                loaded_r  <= loaded_r | (wr_addr_r == ADDR_LAST);
            end else begin
                wr_addr_r <= wr_addr_r;
                loaded_r  <= loaded_r;
            end

            if ((state_r == FRST) && (state_nx == FRST)) begin
                rst_cnt_r <= rst_cnt_r + RC_W'(1);
            end else begin
                rst_cnt_r <= '0;
            end

            // Frame tracking follows the segment on si; since TOTAL = N*LL the
            // frame and LUT counters wrap together with the read address.
            if (run_hold_s) begin
                if (seg_cnt_r == SEG_LAST) begin
                    seg_cnt_r <= '0;
                    lut_n_r   <= (lut_n_r == LUT_LAST) ? '0 : (lut_n_r + N_W'(1));
                end else begin
                    seg_cnt_r <= seg_cnt_r + LL_W'(1);
                    lut_n_r   <= lut_n_r;
                end
                stop_req_r <= stop_req_r | ~run_en;
            end else begin
                seg_cnt_r  <= '0;
                lut_n_r    <= '0;
                stop_req_r <= 1'b0;
            end
        end
    end

    assign ld_ready   = ld_ready_r;
    assign loaded     = loaded_r;
    assign fab_rst    = fab_rst_r;
    assign si         = rd_data_s;
    assign lut_n      = lut_n_r;
    assign sweep_done = sweep_done_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
module tb_s4ga_cfg_streamer;
    import s4ga_pkg::*;

    localparam int N       = 5;
    localparam int K       = 2;
    localparam int SI_W    = 4;
    localparam int N_W     = calc_n_w(N);
    localparam int LL      = calc_ll(N, K, SI_W);
    localparam int TOTAL   = calc_total(N, K, SI_W);
    localparam int RST_CYC = N + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start;
    logic            ld_valid;
    logic [SI_W-1:0] ld_data;
    logic            ld_ready;
    logic            run_en;
    logic            loaded;
    logic            fab_rst;
    logic [SI_W-1:0] si;
    logic [N_W-1:0]  lut_n;
    logic            sweep_done;
    logic [1:0]      state_o;

    typedef struct packed {
        logic [SI_W-1:0] si;
        logic [N_W-1:0]  lut;
        logic            sd;
    } exp_t;

    exp_t            sbq[$];
    logic [SI_W-1:0] img [TOTAL];
    int              checks = 0;
    int              errors = 0;

    s4ga_cfg_streamer #(
        .N    (N),
        .K    (K),
        .SI_W (SI_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .run_en     (run_en),
        .loaded     (loaded),
        .fab_rst    (fab_rst),
        .si         (si),
        .lut_n      (lut_n),
        .sweep_done (sweep_done),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected stream of one full sweep of the current image.
    task automatic push_sweep();
        for (int j = 0; j < TOTAL; j++) begin
            sbq.push_back(exp_t'{si: img[j], lut: N_W'(j / LL), sd: (j == TOTAL - 1)});
        end
    endtask

    // Count fabric-reset cycles after a run request; leaves the bench in the
    // first cycle with fab_rst low (or after the budget expires).
    task automatic wait_frst(output int n);
        n = 0;
        step();
        while (fab_rst === 1'b1 && si === '0 && state_o === 2'd2 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        logic [12:0] got;
        logic [12:0] exp;
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0; run_en = 1'b0;
        step();
        step();
        got = {state_o, fab_rst, si, ld_ready, loaded, sweep_done, lut_n};
        exp = {2'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", got, exp);
        end
        rst = 1'b0;
        run_en = 1'b1;
        step();
        step();
        checks++;
        if (state_o !== 2'd0 || fab_rst !== 1'b1) begin
            errors++;
            $display("FAIL run_without_image: state %0d fab_rst %b expected state 0 fab_rst 1", state_o, fab_rst);
        end
        run_en = 1'b0;
    endtask

    task automatic test_load_b2b();
        int n_ready = 0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            if (ld_ready === 1'b1) n_ready++;
            ld_valid = 1'b1;
            ld_data  = SI_W'(i);
            img[i]   = SI_W'(i);
            step();
        end
        ld_valid = 1'b0;
        checks++;
        if (n_ready != TOTAL) begin
            errors++;
            $display("FAIL b2b_ready_cycles: got %0d expected %0d", n_ready, TOTAL);
        end
        checks++;
        if (state_o !== 2'd0 || loaded !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: state %0d loaded %b ld_ready %b expected 0 1 0", state_o, loaded, ld_ready);
        end
    endtask

    task automatic test_load_toggle();
        int acc = 0;
        int cyc = 0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        checks++;
        if (state_o !== 2'd1 || loaded !== 1'b0) begin
            errors++;
            $display("FAIL toggle_enter: state %0d loaded %b expected 1 0", state_o, loaded);
        end
        while (acc < TOTAL && cyc < 100) begin
            ld_valid   = (cyc % 2 == 0);
            ld_data    = ld_valid ? SI_W'(acc) : 4'hF;
            load_start = (cyc == 6);
            run_en     = (cyc == 7);
            if (ld_valid && ld_ready === 1'b1) begin
                img[acc] = SI_W'(acc);
                acc++;
            end
            cyc++;
            step();
        end
        ld_valid = 1'b0; load_start = 1'b0; run_en = 1'b0;
        checks++;
        if (cyc != 2 * TOTAL - 1) begin
            errors++;
            $display("FAIL toggle_cycles: got %0d expected %0d", cyc, 2 * TOTAL - 1);
        end
        checks++;
        if (state_o !== 2'd0 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL toggle_done: state %0d loaded %b expected 0 1", state_o, loaded);
        end
    endtask

    task automatic test_run();
        int   n;
        exp_t e;
        push_sweep();
        push_sweep();
        run_en = 1'b1;
        wait_frst(n);
        checks++;
        if (n != RST_CYC) begin
            errors++;
            $display("FAIL frst_length: got %0d expected %0d", n, RST_CYC);
        end
        for (int j = 0; j <= TOTAL; j++) begin
            e = sbq.pop_front();
            checks++;
            if ({state_o, fab_rst, si, lut_n, sweep_done} !== {2'd3, 1'b0, e.si, e.lut, e.sd}) begin
                errors++;
                $display("FAIL stream_%0d: got st %0d rst %b si %h lut %0d sd %b expected st 3 rst 0 si %h lut %0d sd %b",
                         j, state_o, fab_rst, si, lut_n, sweep_done, e.si, e.lut, e.sd);
            end
            step();
        end
    endtask

    task automatic test_stop();
        exp_t e;
        for (int j = 1; j < TOTAL; j++) begin
            e = sbq.pop_front();
            checks++;
            if ({state_o, fab_rst, si, lut_n, sweep_done} !== {2'd3, 1'b0, e.si, e.lut, e.sd}) begin
                errors++;
                $display("FAIL stop_stream_%0d: got si %h lut %0d sd %b st %0d expected si %h lut %0d sd %b st 3",
                         j, si, lut_n, sweep_done, state_o, e.si, e.lut, e.sd);
            end
            if (j == 5) run_en = 1'b0;
            if (j == 8) run_en = 1'b1;
            step();
        end
        checks++;
        if (state_o !== 2'd0 || fab_rst !== 1'b1 || si !== 4'h0 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL stop_boundary: state %0d fab_rst %b si %h sd %b expected 0 1 0 0", state_o, fab_rst, si, sweep_done);
        end
        run_en = 1'b0;
        step();
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL stop_stays_idle: state %0d expected 0", state_o);
        end
    endtask

    task automatic test_load_start_in_run();
        int   n;
        exp_t e;
        push_sweep();
        run_en = 1'b1;
        wait_frst(n);
        checks++;
        if (n != RST_CYC) begin
            errors++;
            $display("FAIL ls_frst_length: got %0d expected %0d", n, RST_CYC);
        end
        for (int j = 0; j < TOTAL; j++) begin
            e = sbq.pop_front();
            checks++;
            if ({state_o, si, lut_n, sweep_done} !== {2'd3, e.si, e.lut, e.sd}) begin
                errors++;
                $display("FAIL ls_stream_%0d: got st %0d si %h lut %0d sd %b expected st 3 si %h lut %0d sd %b",
                         j, state_o, si, lut_n, sweep_done, e.si, e.lut, e.sd);
            end
            load_start = (j == 4);
            if (j == 7) run_en = 1'b0;
            step();
        end
        load_start = 1'b0;
        checks++;
        if (state_o !== 2'd0 || loaded !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL ls_end: state %0d loaded %b ld_ready %b expected 0 1 0", state_o, loaded, ld_ready);
        end
    endtask

    task automatic test_simul_start();
        int   n;
        exp_t e;
        load_start = 1'b1;
        run_en     = 1'b1;
        step();
        load_start = 1'b0;
        checks++;
        if (state_o !== 2'd1 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_priority: state %0d ld_ready %b expected 1 1", state_o, ld_ready);
        end
        for (int i = 0; i < TOTAL; i++) begin
            ld_valid = 1'b1;
            ld_data  = SI_W'(TOTAL - 1 - i);
            img[i]   = SI_W'(TOTAL - 1 - i);
            step();
        end
        ld_valid = 1'b0;
        checks++;
        if (state_o !== 2'd0 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL simul_load_done: state %0d loaded %b expected 0 1", state_o, loaded);
        end
        push_sweep();
        wait_frst(n);
        checks++;
        if (n != RST_CYC) begin
            errors++;
            $display("FAIL simul_frst_length: got %0d expected %0d", n, RST_CYC);
        end
        for (int j = 0; j < TOTAL; j++) begin
            e = sbq.pop_front();
            checks++;
            if ({state_o, fab_rst, si, lut_n, sweep_done} !== {2'd3, 1'b0, e.si, e.lut, e.sd}) begin
                errors++;
                $display("FAIL reload_stream_%0d: got si %h lut %0d sd %b expected si %h lut %0d sd %b",
                         j, si, lut_n, sweep_done, e.si, e.lut, e.sd);
            end
            if (j == 0) run_en = 1'b0;
            step();
        end
        checks++;
        if (state_o !== 2'd0 || fab_rst !== 1'b1 || si !== 4'h0) begin
            errors++;
            $display("FAIL reload_stop: state %0d fab_rst %b si %h expected 0 1 0", state_o, fab_rst, si);
        end
    endtask

    task automatic test_rst_mid();
        int          n;
        int          n_idle = 0;
        exp_t        e;
        logic [12:0] got;
        logic [12:0] exp;
        push_sweep();
        run_en = 1'b1;
        wait_frst(n);
        checks++;
        if (n != RST_CYC) begin
            errors++;
            $display("FAIL rst_frst_length: got %0d expected %0d", n, RST_CYC);
        end
        for (int j = 0; j < 8; j++) begin
            e = sbq.pop_front();
            checks++;
            if ({si, lut_n} !== {e.si, e.lut}) begin
                errors++;
                $display("FAIL rst_stream_%0d: got si %h lut %0d expected si %h lut %0d", j, si, lut_n, e.si, e.lut);
            end
            if (j == 7) rst = 1'b1;
            step();
        end
        sbq.delete();
        got = {state_o, fab_rst, si, ld_ready, loaded, sweep_done, lut_n};
        exp = {2'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL mid_reset_values: got %h expected %h", got, exp);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (state_o === 2'd0 && fab_rst === 1'b1) n_idle++;
        end
        checks++;
        if (n_idle != 5) begin
            errors++;
            $display("FAIL no_run_after_reset: idle cycles %0d expected 5", n_idle);
        end
        run_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0; run_en = 1'b0;
        test_reset();
        test_load_b2b();
        test_load_toggle();
        test_run();
        test_stop();
        test_load_start_in_run();
        test_simul_start();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
